sap_core_param: RTL

- Parametrised next-generation SAP computer core. It integrates the PC, MAR, RAM, IR, A, B, adder/subtractor and output register, all driven by a variable-length ring-counter sequencer.
- Width and depth are generic. Adds STA, LDI, JMP, JC and JZ, plus carry/zero flags.
- Each instruction ends early, returning to T1 once its last useful step is done.
- Sits as the CPU top under the board wrapper; switches/LEDs connect straight to its ports.

---
 rtl/sap_core_param_if.sv | 30 +++
 rtl/sap_core_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sap_core_param_if.sv
// Bus bundle for the SAP core: program-load strobes in, architectural state out.
// The master side (board wrapper or bench) drives run/load signals.
// The slave side (the core) drives the visible registers and the status signals.
interface sap_core_param_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              run;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_we;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [5:0]        ring;
    logic              carry;
    logic              zero;

    modport master (
        output run, prog_addr, prog_data, prog_we,
        input  out, out_valid, halted, pc, acc, ring, carry, zero
    );

    modport slave (
        input  run, prog_addr, prog_data, prog_we,
        output out, out_valid, halted, pc, acc, ring, carry, zero
    );
endinterface

// File: rtl/sap_core_param.sv
// Parametrised SAP CPU core. A one-hot ring counter (T1..T6) sequences fetch
// and execute. Each instruction returns to T1 as soon as its last useful
// step is done. The RAM is read asynchronously at MAR. It is written either
// by the loader (run=0) or by STA at T5.
module sap_core_param #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            n_clr,
    sap_core_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // The state encoding is the ring itself. HALT is the all-zero ring.
    typedef enum logic [5:0] {
        T1   = 6'b000001,
        T2   = 6'b000010,
        T3   = 6'b000100,
        T4   = 6'b001000,
        T5   = 6'b010000,
        T6   = 6'b100000,
        HALT = 6'b000000
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] out_q;
    logic              out_valid_q;
    logic              halted_q;
    logic              carry_q;
    logic              zero_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [3:0]        op_d;
    logic [ADDR_W-1:0] opr_d;
    logic [DATA_W-1:0] opr_ext_d;
    logic [DATA_W-1:0] ram_rd_d;
    logic              is_sub_d;
    logic [DATA_W:0]   sum_d;
    logic              sta_we_d;

    // Instruction decode, asynchronous RAM read and the shared adder/subtractor.
    // SUB adds ~B + 1, so the adder's carry-out means "no borrow".
    always_comb begin
        op_d      = ir_q[DATA_W-1 -: 4];
        opr_d     = ir_q[ADDR_W-1:0];
        opr_ext_d = {{(DATA_W-ADDR_W){1'b0}}, opr_d};
        ram_rd_d  = mem_q[mar_q];
        is_sub_d  = (op_d == OP_SUB);
        sum_d     = {1'b0, a_q} + {1'b0, (is_sub_d ? ~b_q : b_q)}
                    + {{DATA_W{1'b0}}, is_sub_d};
        sta_we_d  = bus.run && (state_q == T5) && (op_d == OP_STA);
    end

    // RAM writes: the loader writes while stopped, STA writes at T5 while
    // running. Both are gated by run, so dropping run cancels a pending STA.
    always_ff @(posedge clk) begin
        if (n_clr) begin
            if (!bus.run && bus.prog_we) begin
                mem_q[bus.prog_addr] <= bus.prog_data;
            end else if (sta_we_d) begin
                mem_q[mar_q] <= a_q;
            end
        end
    end

    // Sequencer and datapath registers. Loading mode forces a clean restart at T1.
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state_q     <= T1;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else if (!bus.run) begin
            state_q     <= T1;
            pc_q        <= '0;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                T1: begin
                    mar_q   <= pc_q;
                    state_q <= T2;
                end
                T2: begin
                    pc_q    <= pc_q + 1'b1;
                    state_q <= T3;
                end
                T3: begin
                    ir_q    <= ram_rd_d;
                    state_q <= T4;
                end
                T4: begin
                    state_q <= T1;
                    case (op_d)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar_q   <= opr_d;
                            state_q <= T5;
                        end
                        OP_LDI: a_q <= opr_ext_d;
                        OP_JMP: pc_q <= opr_d;
                        OP_JC: begin
                            if (carry_q) pc_q <= opr_d;
                        end
                        OP_JZ: begin
                            if (zero_q) pc_q <= opr_d;
                        end
                        OP_OUT: begin
                            out_q       <= a_q;
                            out_valid_q <= 1'b1;
                        end
                        OP_HLT: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    state_q <= T1;
                    case (op_d)
                        OP_LDA: a_q <= ram_rd_d;
                        OP_ADD, OP_SUB: begin
                            b_q     <= ram_rd_d;
                            state_q <= T6;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    a_q     <= sum_d[DATA_W-1:0];
                    carry_q <= sum_d[DATA_W];
                    zero_q  <= (sum_d[DATA_W-1:0] == '0);
                    state_q <= T1;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: state_q <= T1;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.halted    = halted_q;
    assign bus.pc        = pc_q;
    assign bus.acc       = a_q;
    assign bus.ring      = state_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
endmodule
